// File: rtl/scanlines_pro.sv
// scanlines_pro: scanline darkening stage with frame-start shadowed settings and a fixed DELAY-cycle pipeline.
// Optional alternate-frame line shift is enabled by defining SCANLINES_PRO_FRAME_ALT_EN.
module scanlines_pro #(
  parameter int DW     = 8,
  parameter int PHASES = 4,
  parameter int DELAY  = 3,
  parameter int BLANK  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          period,
  input  logic [PHASES-1:0]   dark_mask,
  input  logic [3:0]          level,
  input  logic [3*DW-1:0]     din,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                de_in,
  output logic [3*DW-1:0]     dout,
  output logic                hs_out,
  output logic                vs_out,
  output logic                de_out
);
  localparam int LW = $clog2(PHASES);
  localparam logic [2:0] PMAX = 3'(PHASES - 1);
  logic              vs_prev, hs_prev, vs_fall, hs_fall;
  logic [2:0]        sh_period, p, p_new;
  logic [PHASES-1:0] sh_mask;
  logic [3:0]        sh_level;
  logic [LW-1:0]     lc, lc_start, lc_next;
  logic              dark;
  logic [4:0]        f, f1;
  logic [3*DW-1:0]   d1, scaled;
  logic [3*DW-1:0]   d_q [2:DELAY];
  logic [DELAY:1]    hs_q, vs_q, de_q;
`ifdef SCANLINES_PRO_FRAME_ALT_EN
  logic              parity;
`endif

  always_comb begin
    vs_fall  = vs_prev & ~vs_in;
    hs_fall  = hs_prev & ~hs_in;
    p        = (sh_period > PMAX) ? PMAX : sh_period;
    p_new    = (period > PMAX) ? PMAX : period;
`ifdef SCANLINES_PRO_FRAME_ALT_EN
    lc_start = (parity && p_new != 3'd0) ? LW'(1) : '0;
`else
    lc_start = '0;
`endif
    lc_next  = (3'(lc) >= p) ? '0 : lc + LW'(1);
    dark     = (p != 3'd0) && sh_mask[lc];
    f        = (dark && sh_level != 4'd0) ? 5'd16 - {1'b0, sh_level} : 5'd16;
  end

  // Line state; vs falling edge takes priority over a coincident hs edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev   <= 1'b0;
      hs_prev   <= 1'b0;
      sh_period <= '0;
      sh_mask   <= '0;
      sh_level  <= '0;
      lc        <= '0;
`ifdef SCANLINES_PRO_FRAME_ALT_EN
      parity    <= 1'b0;
`endif
    end else begin
      vs_prev <= vs_in;
      hs_prev <= hs_in;
      if (vs_fall) begin
        sh_period <= period;
        sh_mask   <= dark_mask;
        sh_level  <= level;
        lc        <= lc_start;
`ifdef SCANLINES_PRO_FRAME_ALT_EN
        parity    <= ~parity;
`endif
      end else if (hs_fall) begin
        lc <= lc_next;
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [DW+4:0] prod;
    assign prod = (DW+5)'(d1[c*DW +: DW]) * (DW+5)'(f1);
    assign scaled[c*DW +: DW] = DW'(prod >> 4);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1   <= '0;
      f1   <= 5'd16;
      d_q  <= '{default: '0};
      hs_q <= '0;
      vs_q <= '0;
      de_q <= '0;
    end else begin
      d1     <= din;
      f1     <= f;
      d_q[2] <= scaled;
      for (int k = 3; k <= DELAY; k++) d_q[k] <= d_q[k-1];
      hs_q   <= {hs_q[DELAY-1:1], hs_in};
      vs_q   <= {vs_q[DELAY-1:1], vs_in};
      de_q   <= {de_q[DELAY-1:1], de_in};
    end
  end

  assign dout   = (BLANK != 0 && !de_q[DELAY]) ? '0 : d_q[DELAY];
  assign hs_out = hs_q[DELAY];
  assign vs_out = vs_q[DELAY];
  assign de_out = de_q[DELAY];
endmodule

// File: tb/tb_scanlines_pro.sv
// tb_scanlines_pro: table vectors, directed corner sequences and random traffic against a line-count reference model.
module tb_scanlines_pro;
  localparam int DELAY = 3;
`ifdef SCANLINES_PRO_FRAME_ALT_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b1;
  logic [2:0]  period = '0;
  logic [3:0]  dark_mask = '0, level = '0;
  logic [23:0] din = '0;
  logic        hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [23:0] dout, dout_nb;
  logic        hs_out, vs_out, de_out, hs_nb, vs_nb, de_nb;
  int          pass_cnt = 0, total = 0;

  typedef struct { logic [23:0] d, dnb; logic hs, vs, de; } exp_t;
  typedef struct { logic [3:0] lvl; logic [23:0] pix, res; } vec_t;
  exp_t q[$];
  logic [2:0] m_period;
  logic [3:0] m_mask, m_level;
  int         m_n, m_start;
  bit         m_par, m_pvs, m_phs;

  scanlines_pro #(.DW(8), .PHASES(4), .DELAY(DELAY), .BLANK(1)) dut (
    .clk(clk), .reset_n(reset_n), .period(period), .dark_mask(dark_mask), .level(level),
    .din(din), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .dout(dout), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out));

  scanlines_pro #(.DW(8), .PHASES(4), .DELAY(DELAY), .BLANK(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .period(period), .dark_mask(dark_mask), .level(level),
    .din(din), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .dout(dout_nb), .hs_out(hs_nb), .vs_out(vs_nb), .de_out(de_nb));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] scale(input logic [23:0] c, input int g);
    logic [23:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch*8 +: 8] = 8'((int'(c[ch*8 +: 8]) * g) / 16);
    return r;
  endfunction

  task automatic step();
    exp_t e;
    int p, idx, g;
    bit vf, hf;
    p   = (m_period > 3) ? 3 : int'(m_period);
    idx = (p == 0) ? 0 : (m_start + m_n) % (p + 1);
    g   = (p != 0 && m_mask[idx]) ? 16 - int'(m_level) : 16;
    e.dnb = scale(din, g);
    e.d   = de_in ? e.dnb : 24'h0;
    e.hs  = hs_in; e.vs = vs_in; e.de = de_in;
    q.push_back(e);
    vf = m_pvs && !vs_in;
    hf = m_phs && !hs_in;
    if (vf) begin
      m_period = period; m_mask = dark_mask; m_level = level;
      p = (period > 3) ? 3 : int'(period);
      m_start = (ALT && m_par && p != 0) ? 1 : 0;
      m_par = !m_par;
      m_n = 0;
    end else if (hf) m_n++;
    m_pvs = vs_in; m_phs = hs_in;
    @(posedge clk); #1;
    e = q.pop_front();
    check("model", {dout, hs_out, vs_out, de_out}, {e.d, e.hs, e.vs, e.de});
    check("model_nb", {dout_nb, hs_nb, vs_nb, de_nb}, {e.dnb, e.hs, e.vs, e.de});
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1; step(); vs_in = 1'b0; step();
  endtask

  task automatic hs_pulse();
    hs_in = 1'b1; step(); hs_in = 1'b0; step();
  endtask

  task automatic line_chk(input logic [23:0] exp, input string name);
    hold(3);
    check(name, dout, exp);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{d: '0, dnb: '0, hs: 1'b0, vs: 1'b0, de: 1'b0};
    reset_n = 1'b0; #1;
    check("reset_out", {dout, hs_out, vs_out, de_out, dout_nb}, '0);
    m_period = '0; m_mask = '0; m_level = '0; m_n = 0; m_start = 0;
    m_par = 1'b0; m_pvs = 1'b0; m_phs = 1'b0;
    q.delete();
    repeat (DELAY - 1) q.push_back(z);
    @(posedge clk); #1;
    check("reset_hold", {dout, hs_out, vs_out, de_out}, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{lvl: 4'd0,  pix: 24'hA0B0C0, res: 24'hA0B0C0};
    vt[1] = '{lvl: 4'd8,  pix: 24'h808080, res: 24'h404040};
    vt[2] = '{lvl: 4'd12, pix: 24'h808080, res: 24'h202020};
    vt[3] = '{lvl: 4'd15, pix: 24'hFFFFFF, res: 24'h0F0F0F};
    vt[4] = '{lvl: 4'd1,  pix: 24'hFF0010, res: 24'hEF000F};
    vt[5] = '{lvl: 4'd4,  pix: 24'h010203, res: 24'h000102};
    vt[6] = '{lvl: 4'd15, pix: 24'h101010, res: 24'h010101};

    do_reset();
    din = 24'hA0B0C0; de_in = 1'b1;
    step(); check("lat1", dout, 24'h0);
    step(); check("lat2", dout, 24'h0);
    step(); check("lat3", dout, 24'hA0B0C0);
    hold(2);
    do_reset();

    period = 3'd1; dark_mask = 4'b0011; de_in = 1'b1;
    foreach (vt[i]) begin
      level = vt[i].lvl;
      vs_pulse();
      din = vt[i].pix;
      hold(3);
      check($sformatf("vec%0d", i), dout, vt[i].res);
    end

    do_reset();
    period = 3'd1; dark_mask = 4'b0010; level = 4'd8; din = 24'h808080; de_in = 1'b1;
    vs_pulse();
    line_chk(24'h808080, "shadow_l0"); hs_pulse();
    line_chk(24'h404040, "shadow_l1"); level = 4'd12; hs_pulse();
    line_chk(24'h808080, "shadow_l2"); hs_pulse();
    line_chk(24'h404040, "shadow_l3_old_level");
    vs_pulse();
    line_chk(ALT ? 24'h202020 : 24'h808080, "shadow_new_l0"); hs_pulse();
    line_chk(ALT ? 24'h808080 : 24'h202020, "shadow_new_l1");

    do_reset();
    period = 3'd7; dark_mask = 4'b1000; level = 4'd15; din = 24'hFFFFFF;
    vs_pulse();
    for (int l = 0; l < 8; l++) begin
      line_chk((l % 4 == 3) ? 24'h0F0F0F : 24'hFFFFFF, $sformatf("clamp_l%0d", l));
      hs_pulse();
    end

    do_reset();
    period = 3'd3; dark_mask = 4'b0001; level = 4'd8; din = 24'h808080;
    vs_pulse();
    line_chk(24'h404040, "sim_l0"); hs_pulse(); hs_pulse();
    line_chk(24'h808080, "sim_l2");
    vs_in = 1'b1; hs_in = 1'b1; step();
    vs_in = 1'b0; hs_in = 1'b0; step();
    line_chk(ALT ? 24'h808080 : 24'h404040, "sim_after"); hs_pulse();
    line_chk(24'h808080, "sim_next");

    do_reset();
    period = 3'd0; de_in = 1'b0; din = 24'h123456; hs_in = 1'b1; vs_in = 1'b1;
    step(); step();
    check("blank_hs_early", hs_out, 1'b0);
    step();
    check("blank_dout", dout, 24'h0);
    check("blank_nb_dout", dout_nb, 24'h123456);
    check("blank_hs", hs_out, 1'b1);
    check("blank_vs", vs_out, 1'b1);
    hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b1;
    hold(3);

`ifdef SCANLINES_PRO_FRAME_ALT_EN
    do_reset();
    period = 3'd1; dark_mask = 4'b0001; level = 4'd8; din = 24'h808080;
    for (int fr = 0; fr < 3; fr++) begin
      vs_pulse();
      for (int l = 0; l < 4; l++) begin
        line_chk(((l + fr) % 2 == 0) ? 24'h404040 : 24'h808080, $sformatf("alt_f%0d_l%0d", fr, l));
        hs_pulse();
      end
    end
`endif

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 2000; i++) begin
        din = 24'($urandom);
        de_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) hs_in = ~hs_in;
        if ($urandom_range(0, 60) == 0) vs_in = ~vs_in;
        if ($urandom_range(0, 20) == 0) begin
          period = 3'($urandom); dark_mask = 4'($urandom); level = 4'($urandom);
        end
        step();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
